vga_fb_scaler: RTL and testbench



---
 rtl/vga_fb_scaler.sv | 137 +++++++++++++
 tb/tb_vga_fb_scaler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scaler.sv
// Framebuffer raster reader: integer pixel replication, wrapped vertical scroll,
// optional 256-entry palette, fixed 4-cycle latency from dot coordinates to rgb.
module vga_fb_scaler #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 1024,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned BPC        = 3,
  parameter int unsigned OUT_BPC    = 4,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic                   clk_dot,
  input  logic                   reset,
  input  logic                   vid_active,
  input  logic [11:0]            x_cnt,
  input  logic [11:0]            y_cnt,
  input  logic [11:0]            scroll_y,
  input  logic                   mode_palette,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [3*BPC-1:0]       wr_data,
  input  logic                   pal_wr_en,
  input  logic [7:0]             pal_wr_addr,
  input  logic [3*OUT_BPC-1:0]   pal_wr_data,
  output logic [3*OUT_BPC-1:0]   rgb
);

  localparam int unsigned FB_W  = H_ACTIVE >> SCALE_LOG2;
  localparam int unsigned FB_H  = V_ACTIVE >> SCALE_LOG2;
  localparam int unsigned DEPTH = FB_W * FB_H;
  localparam int unsigned PIX_W = 3 * BPC;
  localparam int unsigned OUT_W = 3 * OUT_BPC;

  // Frame-latched controls and pipeline flags.
  logic [11:0]       scroll_q;
  logic              mode_q;
  logic              rst_d;
  logic              act1, act2, act3;
  logic              mode1, mode2, mode3;

  // Stage-1 address generation.
  logic              frame_start;
  logic [11:0]       scroll_in;
  logic [11:0]       scroll_eff;
  logic              mode_eff;
  logic [12:0]       row_sum;
  logic [12:0]       row;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] addr_nxt;
  logic              act_nxt;
  logic [ADDR_W-1:0] addr1;

  // Storage and read data.
  logic [PIX_W-1:0]  fb_mem  [DEPTH];
  logic [OUT_W-1:0]  pal_mem [256];
  logic [PIX_W-1:0]  fb_rd;
  logic [7:0]        pal_idx;
  logic [OUT_W-1:0]  pal_rd;
  logic [OUT_W-1:0]  dir3;
  logic [OUT_W-1:0]  colour3;
  logic              wr_ok;

  function automatic logic [OUT_W-1:0] expand(input logic [PIX_W-1:0] p);
    logic [OUT_W-1:0] e;
    e = '0;
    for (int c = 0; c < 3; c++)
      e[c*OUT_BPC +: OUT_BPC] = OUT_BPC'(p[c*BPC +: BPC]) << (OUT_BPC - BPC);
    return e;
  endfunction

  // The frame-start pixel itself must already see the newly latched scroll and mode.
  always_comb begin
    frame_start = (x_cnt == 12'd0) && (y_cnt == 12'd0);
    scroll_in   = (32'(scroll_y) >= FB_H) ? 12'd0 : scroll_y;
    scroll_eff  = frame_start ? scroll_in : scroll_q;
    mode_eff    = frame_start ? mode_palette : mode_q;
    row_sum     = 13'(y_cnt >> SCALE_LOG2) + 13'(scroll_eff);
    row         = (32'(row_sum) >= FB_H) ? row_sum - 13'(FB_H) : row_sum;
    addr_full   = 32'(row) * FB_W + 32'(x_cnt >> SCALE_LOG2);
    addr_nxt    = (addr_full < DEPTH) ? addr_full[ADDR_W-1:0] : '0;
    // The first sample after reset is also dropped so rgb stays dark through the
    // fourth edge after release.
    act_nxt     = vid_active && (32'(x_cnt) < H_ACTIVE) &&
                  (32'(y_cnt) < V_ACTIVE) && !rst_d;
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples the
  // previous stage's value from before the edge, independent of block order.
  always_ff @(posedge clk_dot) begin
    if (reset) begin
      scroll_q <= '0;
      mode_q   <= 1'b0;
      rst_d    <= 1'b1;
      act1     <= 1'b0;
      act2     <= 1'b0;
      act3     <= 1'b0;
      rgb      <= '0;
    end else begin
      rst_d <= 1'b0;
      if (frame_start) begin
        scroll_q <= scroll_in;
        mode_q   <= mode_palette;
      end
      act1 <= act_nxt;
      act2 <= act1;
      act3 <= act2;
      rgb  <= act3 ? colour3 : '0;
    end
  end

  // Datapath registers carry no reset: the act flags alone decide visibility.
  always_ff @(posedge clk_dot) begin
    addr1 <= addr_nxt;
    mode1 <= mode_eff;
    mode2 <= mode1;
    mode3 <= mode2;
    dir3  <= expand(fb_rd);
  end

  assign wr_ok   = wr_en && (32'(wr_addr) < DEPTH);
  assign pal_idx = 8'(fb_rd);
  assign colour3 = mode3 ? pal_rd : dir3;

  // NOTE: block RAM contents are never reset; a reset port would prevent RAM inference.
  always_ff @(posedge clk_dot) begin
    if (wr_ok)
      fb_mem[wr_addr] <= wr_data;
    fb_rd <= fb_mem[addr1];
  end

  // Palette read sits in the same stage as dir3 so both modes share one latency.
  always_ff @(posedge clk_dot) begin
    if (pal_wr_en)
      pal_mem[pal_wr_addr] <= pal_wr_data;
    pal_rd <= pal_mem[pal_idx];
  end

endmodule

// File: tb/tb_vga_fb_scaler.sv
// Self-checking bench for vga_fb_scaler: fixed vector table, hand sequences for
// scroll/palette/reset corners, and randomized pixels against a frame-level model.
module tb_vga_fb_scaler;

  localparam int FB_W  = 320;
  localparam int FB_H  = 256;
  localparam int DEPTH = 81920;

  logic        clk_dot = 1'b0;
  logic        reset;
  logic        vid_active;
  logic [11:0] x_cnt, y_cnt, scroll_y;
  logic        mode_palette;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [8:0]  wr_data;
  logic        pal_wr_en;
  logic [7:0]  pal_wr_addr;
  logic [11:0] pal_wr_data;
  logic [11:0] rgb;

  always #5 clk_dot = ~clk_dot;

  vga_fb_scaler dut (
    .clk_dot      (clk_dot),
    .reset        (reset),
    .vid_active   (vid_active),
    .x_cnt        (x_cnt),
    .y_cnt        (y_cnt),
    .scroll_y     (scroll_y),
    .mode_palette (mode_palette),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pal_wr_en    (pal_wr_en),
    .pal_wr_addr  (pal_wr_addr),
    .pal_wr_data  (pal_wr_data),
    .rgb          (rgb)
  );

  typedef struct {
    logic [11:0] exp;
    string       name;
  } exp_t;

  typedef struct {
    bit          vid;
    int          x;
    int          y;
    logic [11:0] exp;
  } vec_t;

  exp_t        exp_q [$];
  logic [8:0]  fb_m  [DEPTH];
  logic [11:0] pal_m [256];
  int          m_scroll;
  bit          m_mode;
  bit          blank_next;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: rgb=%h expected %h", name, act, exp);
    end
  endtask

  // Expected colour of one dot under the currently latched frame settings.
  function automatic logic [11:0] model_pix(input bit vid, input int x, input int y);
    int row, addr;
    logic [8:0] p;
    if (!vid || x >= 1280 || y >= 1024) return 12'h000;
    row  = ((y / 4) + m_scroll) % FB_H;
    addr = row * FB_W + x / 4;
    p    = fb_m[addr];
    if (m_mode) return pal_m[p[7:0]];
    return {p[8:6], 1'b0, p[5:3], 1'b0, p[2:0], 1'b0};
  endfunction

  // Apply one dot for one clock; the result is compared four edges later.
  task automatic drive(input bit vid, input int x, input int y,
                       input bit fixed, input logic [11:0] fexp, input string name);
    exp_t e;
    vid_active = vid;
    x_cnt      = 12'(x);
    y_cnt      = 12'(y);
    e.name     = name;
    if (reset) begin
      m_scroll = 0;
      m_mode   = 1'b0;
      foreach (exp_q[i]) begin
        exp_q[i].exp  = 12'h000;
        exp_q[i].name = "reset_flush";
      end
      e.exp      = 12'h000;
      blank_next = 1'b1;
    end else begin
      if (x == 0 && y == 0) begin
        m_scroll = (scroll_y >= 12'd256) ? 0 : int'(scroll_y);
        m_mode   = mode_palette;
      end
      if (blank_next) begin
        e.exp  = 12'h000;
        e.name = "reset_blank";
      end else begin
        e.exp = model_pix(vid, x, y);
      end
      blank_next = 1'b0;
    end
    if (fixed) e.exp = fexp;
    exp_q.push_back(e);
    @(posedge clk_dot);
    #1;
    if (exp_q.size() >= 4) begin
      e = exp_q.pop_front();
      check(e.name, rgb, e.exp);
    end
  endtask

  task automatic pix(input bit vid, input int x, input int y);
    drive(vid, x, y, 1'b0, 12'h000, "model");
  endtask

  task automatic pixk(input bit vid, input int x, input int y,
                      input logic [11:0] exp, input string name);
    drive(vid, x, y, 1'b1, exp, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 2000, 2000);
  endtask

  task automatic fb_write(input int a, input logic [8:0] d);
    wr_en   = 1'b1;
    wr_addr = 17'(a);
    wr_data = d;
    if (a < DEPTH) fb_m[a] = d;
    idle(1);
    wr_en = 1'b0;
  endtask

  task automatic pal_write(input int a, input logic [11:0] d);
    pal_wr_en   = 1'b1;
    pal_wr_addr = 8'(a);
    pal_wr_data = d;
    pal_m[a]    = d;
    idle(1);
    pal_wr_en = 1'b0;
  endtask

  // Scroll values whose visible rows stay inside the pre-filled region.
  function automatic logic [11:0] safe_scroll();
    int r;
    r = $urandom_range(0, 17);
    if (r <= 8)  return 12'(r);
    if (r <= 16) return 12'(248 + r - 9);
    return 12'd300;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: rgb=%h at time %0t, expected end of test", rgb, $time);
    $fatal(1);
  end

  initial begin
    vec_t tbl [13];
    tbl = '{
      '{1'b1,    0,    0, 12'hEEE},
      '{1'b1,    3,    0, 12'hEEE},
      '{1'b1,    1,    2, 12'hEEE},
      '{1'b1,    3,    3, 12'hEEE},
      '{1'b1,    4,    0, 12'h000},
      '{1'b1,    7,    3, 12'h000},
      '{1'b1,    0,    4, 12'h00E},
      '{1'b1,    3,    7, 12'h00E},
      '{1'b1,    0,    3, 12'hEEE},
      '{1'b0,    0,    1, 12'h000},
      '{1'b1, 1280,    0, 12'h000},
      '{1'b1,    0, 1024, 12'h000},
      '{1'b1, 4095, 4095, 12'h000}
    };

    n_checks     = 0;
    n_fail       = 0;
    blank_next   = 1'b0;
    m_scroll     = 0;
    m_mode       = 1'b0;
    reset        = 1'b1;
    vid_active   = 1'b0;
    x_cnt        = '0;
    y_cnt        = '0;
    scroll_y     = '0;
    mode_palette = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    pal_wr_en    = 1'b0;
    pal_wr_addr  = '0;
    pal_wr_data  = '0;

    idle(1);
    check("reset_rgb", rgb, 12'h000);
    idle(1);
    reset = 1'b0;
    idle(3);

    fb_write(0, 9'h1FF);
    fb_write(1, 9'h000);
    fb_write(320, 9'h007);

    // Direct replication and row addressing from a fresh frame with no scroll.
    scroll_y     = 12'd0;
    mode_palette = 1'b0;
    foreach (tbl[i]) pixk(tbl[i].vid, tbl[i].x, tbl[i].y, tbl[i].exp, $sformatf("vec%0d", i));

    // Scroll latch, wrap and clamp.
    scroll_y = 12'd1;
    pixk(1'b1, 0, 0, 12'h00E, "scroll1_top");
    scroll_y = 12'd0;
    pixk(1'b1, 3, 0, 12'h00E, "scroll_hold_midframe");
    pixk(1'b1, 0, 1020, 12'hEEE, "scroll1_wrap_bottom");
    scroll_y = 12'd255;
    pixk(1'b0, 0, 0, 12'h000, "scroll255_fs_blank");
    pixk(1'b1, 0, 4, 12'hEEE, "scroll255_wrap");
    pixk(1'b1, 4, 4, 12'h000, "scroll255_col1");
    scroll_y = 12'd300;
    pixk(1'b1, 0, 0, 12'hEEE, "scroll300_clamp");
    pixk(1'b1, 0, 4, 12'h00E, "scroll300_row1");

    // Palette mode switches exactly at the frame-start pixel.
    pal_write(8'hFF, 12'h123);
    fb_write(0, 9'h0FF);
    mode_palette = 1'b1;
    pixk(1'b1, 0, 1, 12'h6EE, "mode_before_fs");
    pixk(1'b1, 0, 0, 12'h123, "pal_first_pixel");
    mode_palette = 1'b0;
    pixk(1'b1, 2, 0, 12'h123, "pal_hold_x");
    pixk(1'b1, 1, 3, 12'h123, "pal_hold_y");
    pixk(1'b1, 0, 0, 12'h6EE, "direct_next_frame");

    // Out-of-range writes and blanking bounds.
    fb_write(81920, 9'h1AA);
    fb_write(131071, 9'h155);
    pixk(1'b1, 0, 1, 12'h6EE, "oob_write_ignored");
    pixk(1'b0, 0, 1, 12'h000, "vid_off");
    pixk(1'b1, 1280, 0, 12'h000, "x_1280");
    idle(4);

    // Fill rows 0..15 and 248..255 plus the whole palette with random data.
    for (int r = 0; r < 24; r++) begin
      int row;
      row = (r < 16) ? r : 232 + r;
      for (int c = 0; c < FB_W; c++) fb_write(row * FB_W + c, 9'($urandom));
    end
    for (int p = 0; p < 256; p++) pal_write(p, 12'($urandom));

    // Random frames: settings latched at frame start, random dots inside.
    for (int f = 0; f < 30; f++) begin
      scroll_y     = safe_scroll();
      mode_palette = 1'($urandom);
      pix(1'($urandom), 0, 0);
      for (int k = 0; k < 80; k++) begin
        int x, y;
        bit vid;
        if ($urandom_range(0, 9) == 0) begin
          scroll_y     = safe_scroll();
          mode_palette = 1'($urandom);
        end
        x   = $urandom_range(0, 1400);
        y   = ($urandom_range(0, 15) == 0) ? $urandom_range(1024, 4095) : $urandom_range(0, 31);
        vid = ($urandom_range(0, 7) != 0);
        pix(vid, x, y);
      end
    end
    idle(4);

    // One-cycle reset in the middle of a palette-mode line.
    scroll_y     = 12'd1;
    mode_palette = 1'b1;
    pix(1'b0, 0, 0);
    for (int x = 496; x < 500; x++) pix(1'b1, x, 10);
    reset = 1'b1;
    pix(1'b1, 500, 10);
    check("reset_mid_rgb", rgb, 12'h000);
    reset = 1'b0;
    for (int x = 501; x < 530; x++) pix(1'b1, x, 10);
    pix(1'b1, 0, 0);
    for (int x = 1; x < 12; x++) pix(1'b1, x * 9, 6);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
